// File: rtl/smc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : smc_pkg
//  Purpose  : Shared definitions for the SMC front end: frame geometry,
//             loader state encoding and SMC mode encodings.
//  Revision : 1.0 - initial release
// ============================================================================
package smc_pkg;

    // Frame geometry, fixed by the SMC port list
    localparam int N_DEV = 6;    // devices per frame
    localparam int DW    = 3;    // width of each Vgs/Vds/W field
    localparam int OW    = 10;   // width of the SMC result
    localparam int CW    = 3;    // beat counter width (range 0..5)

    // Loader states
    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        EVAL    = 2'd1,
        DONE    = 2'd2
    } state_t;

    // SMC mode encodings: bit 0 selects the computed quantity
    localparam logic [1:0] MODE_GM_0 = 2'b00;
    localparam logic [1:0] MODE_ID_0 = 2'b01;
    localparam logic [1:0] MODE_GM_1 = 2'b10;
    localparam logic [1:0] MODE_ID_1 = 2'b11;

    // True when the mode asks SMC for drain current rather than gm
    function automatic logic mode_is_id(input logic [1:0] m);
        return m[0];
    endfunction

endpackage : smc_pkg
`default_nettype wire

// File: rtl/smc_loader.sv
`default_nettype none
// ============================================================================
//  Module   : smc_loader
//  Purpose  : Sequential front end for the combinational SMC. Collects six
//             (Vgs, Vds, W) beats plus a frame mode over a valid/ready stream,
//             presents them as a stable parallel bus, then registers the SMC
//             result and hands it downstream over valid/ready.
//  Ports    :
//     clk, rst                 clock, asynchronous active-high reset
//     in_valid/in_ready        input beat handshake
//     in_first                 marks beat 0 of a frame (forces resync)
//     in_mode                  frame mode, latched on beat 0
//     in_vgs/in_vds/in_w       one device's parameters
//     mode, Vgs0..5, Vds0..5,
//     W0..5                    registered parallel bus into SMC
//     smc_out                  SMC combinational result
//     result/out_valid/
//     out_ready                registered result handshake
//  Revision : 1.0 - initial release
// ============================================================================
module smc_loader #(
    parameter int N_DEV = smc_pkg::N_DEV,
    parameter int DW    = smc_pkg::DW,
    parameter int OW    = smc_pkg::OW
) (
    input  logic          clk,
    input  logic          rst,
    // input stream
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_first,
    input  logic [1:0]    in_mode,
    input  logic [DW-1:0] in_vgs,
    input  logic [DW-1:0] in_vds,
    input  logic [DW-1:0] in_w,
    // parallel bus to SMC
    output logic [1:0]    mode,
    output logic [DW-1:0] Vgs0,
    output logic [DW-1:0] Vgs1,
    output logic [DW-1:0] Vgs2,
    output logic [DW-1:0] Vgs3,
    output logic [DW-1:0] Vgs4,
    output logic [DW-1:0] Vgs5,
    output logic [DW-1:0] Vds0,
    output logic [DW-1:0] Vds1,
    output logic [DW-1:0] Vds2,
    output logic [DW-1:0] Vds3,
    output logic [DW-1:0] Vds4,
    output logic [DW-1:0] Vds5,
    output logic [DW-1:0] W0,
    output logic [DW-1:0] W1,
    output logic [DW-1:0] W2,
    output logic [DW-1:0] W3,
    output logic [DW-1:0] W4,
    output logic [DW-1:0] W5,
    // SMC result and output stream
    input  logic [OW-1:0] smc_out,
    output logic [OW-1:0] result,
    output logic          out_valid,
    input  logic          out_ready
);

    import smc_pkg::*;

    localparam logic [CW-1:0] LAST_BEAT = CW'(N_DEV - 1);

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] count;
    logic          accept;
    logic          restart;     // beat opens a new frame (slot 0)
    logic [CW-1:0] slot;

    logic [DW-1:0] vgs_q [N_DEV];
    logic [DW-1:0] vds_q [N_DEV];
    logic [DW-1:0] w_q   [N_DEV];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= COLLECT;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and handshake decode
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        accept     = 1'b0;
        restart    = 1'b0;
        slot       = count;

        case (state)
            COLLECT: begin
                in_ready = 1'b1;
                accept   = in_valid;
                // in_first mid-frame drops the partial frame; a beat at
                // count 0 is beat 0 whether or not in_first is set.
                restart  = in_first || (count == '0);
                slot     = in_first ? '0 : count;
                if (accept && !restart && (count == LAST_BEAT)) begin
                    next_state = EVAL;
                end
            end
            EVAL: begin
                next_state = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    next_state = COLLECT;
                end
            end
            default: begin
                next_state = COLLECT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Beat counter, mode latch and result register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            mode      <= '0;
            result    <= '0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                if (restart) begin
                    mode  <= in_mode;
                    count <= CW'(1);
                end else if (count != LAST_BEAT) begin
                    count <= count + CW'(1);
                end
            end
            // SMC inputs have been stable for a full cycle in EVAL
            if (state == EVAL) begin
                result    <= smc_out;
                out_valid <= 1'b1;
            end
            if ((state == DONE) && out_ready) begin
                out_valid <= 1'b0;
                count     <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Device slot registers; only an accepted beat writes, so the SMC
    // bus is glitch-free from EVAL through DONE.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_DEV; i++) begin
                vgs_q[i] <= '0;
                vds_q[i] <= '0;
                w_q[i]   <= '0;
            end
        end else if (accept) begin
            vgs_q[slot] <= in_vgs;
            vds_q[slot] <= in_vds;
            w_q[slot]   <= in_w;
        end
    end

    assign Vgs0 = vgs_q[0];
    assign Vgs1 = vgs_q[1];
    assign Vgs2 = vgs_q[2];
    assign Vgs3 = vgs_q[3];
    assign Vgs4 = vgs_q[4];
    assign Vgs5 = vgs_q[5];
    assign Vds0 = vds_q[0];
    assign Vds1 = vds_q[1];
    assign Vds2 = vds_q[2];
    assign Vds3 = vds_q[3];
    assign Vds4 = vds_q[4];
    assign Vds5 = vds_q[5];
    assign W0   = w_q[0];
    assign W1   = w_q[1];
    assign W2   = w_q[2];
    assign W3   = w_q[3];
    assign W4   = w_q[4];
    assign W5   = w_q[5];

endmodule : smc_loader
`default_nettype wire

// File: doc/smc_loader.md
# smc_loader

Sequential front end for the combinational Supper MOSFET Calculator (SMC).
- Collects six MOSFET parameter triples (Vgs, Vds, W) and the frame mode, one beat per clock over a valid/ready stream.
- Drives them as a stable parallel bus into SMC, then registers SMC's 10-bit result and hands it downstream on a valid/ready output.
- Sits directly upstream of SMC and also captures its output; SMC itself is instantiated beside this block at the integration level, not inside it.

## Interface
Parameters:
- N_DEV, 6, devices per frame; fixed by SMC's port list.
- DW, 3, width of each Vgs/Vds/W field.
- OW, 10, width of the SMC result.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  block can accept a beat.
- in_first  input  1  marks beat 0 of a frame.
- in_mode  input  2  frame mode; sampled on the accepted beat 0 only.
- in_vgs, in_vds, in_w  input  DW each  parameters of one device.
- mode  output  2  registered mode to SMC.
- Vgs0..Vgs5, Vds0..Vds5, W0..W5  output  DW each  registered per-device fields to SMC.
- smc_out  input  OW  SMC combinational result.
- result  output  OW  registered result.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.

## Operation
- Reset values: state=COLLECT, beat count=0, in_ready=1, out_valid=0, result=0. Mode and all Vgs/Vds/W outputs are 0.
- Accept rule: a beat is accepted on a rising edge with in_valid&&in_ready. It is written to device slot [count], then count increments.
- States:
  - COLLECT (in_ready=1): beats are accepted. The accepted beat with count=5 moves the FSM to EVAL.
  - EVAL (in_ready=0, one cycle): the SMC inputs are stable. On the exiting edge, result<=smc_out, out_valid<=1, and the FSM moves to DONE.
  - DONE (in_ready=0): result and out_valid are held. On the edge with out_ready=1, out_valid<=0, count<=0 and the FSM returns to COLLECT.
- Mode latch: mode is updated only on an accepted beat with count=0. It holds through EVAL and DONE.
- Frame resync: an accepted beat with in_first=1 and count≠0 discards the partial frame. That beat is written to slot 0, mode is latched from it, and count becomes 1.
  - Slots not yet rewritten keep their stale values; they are invisible because EVAL requires six new beats.
- in_first=0 on the beat with count=0 is legal; the beat is treated as beat 0.
- Beats presented while in_ready=0 are ignored. No state changes and nothing is buffered.
- Device outputs change only on accepted beats, so SMC inputs are glitch-free from EVAL through DONE.
- Reset asserted mid-frame or in DONE forces the reset values immediately; the frame is lost.

## Timing
- Last beat accepted at edge E; EVAL runs in cycle E..E+1; result and out_valid are visible after edge E+1.
- Minimum frame period is 8 cycles (6 COLLECT + 1 EVAL + 1 DONE with out_ready held at 1).
- in_ready deasserts the cycle after the 6th beat is accepted. It reasserts the cycle after the out_valid&&out_ready edge.
- SMC is purely combinational; its settle path from the mode/Vgs/Vds/W registers to smc_out must meet one clock period.

## Structure
- Shared package smc_pkg holds:
  - N_DEV, DW, OW;
  - the state enum {COLLECT, EVAL, DONE};
  - mode encodings: 00/10 select gm, 01/11 select Id.
- Beat counter is 3 bits, range 0..5; it never wraps past 5.
- No sub-module: the FSM, counter and slot registers live in one module with six slot registers indexed by count.

## Test plan
- Reset: assert rst mid-frame after 3 beats -> in_ready=1, out_valid=0, result=0, all device outputs 0; the next 6 beats form a fresh frame.
- Basic frame:
  - Stimulus: mode=01; beats (Vgs,Vds,W)=(1,1,1),(2,2,2)..(6,6,6); bench stub drives smc_out=10'd345.
  - Response: Vgs5=6, W0=1, mode=01 during EVAL; result=345 and out_valid=1 exactly 1 cycle after the 6th accept.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> result and out_valid stable; in_valid beats are ignored with device outputs unchanged. Raising out_ready clears out_valid on the next edge.
- Resync: after 4 beats, send in_first=1 with mode=10, (7,7,7) -> count=1, Vgs0=7, mode=10. A result appears only after 5 more beats.
- Bubbles: in_valid toggles 1/0 every cycle -> the 6th accept lands at cycle 11; result is captured at cycle 12.
- Back-to-back: out_ready tied 1 with continuous in_valid -> one out_valid pulse every 8 cycles and a correct mode per frame.
